egress_frame_transmitter: RTL and testbench

- Transmit-side counterpart of the ingress path, in the tx_clk domain.
- Pops complete frames from a frame-length metadata FIFO and a 32-bit data FIFO, both filled by the egress buffer.
- Drives the MAC-facing EthernetTxBus fields (start, data_valid, bytes_valid, data) and honours the MAC's tx_ready frame-level handshake.
- Frames that arrive while the link is down, or that carry an illegal length, are drained and counted as drops. They are never transmitted.

---
 rtl/egress_frame_transmitter.sv | 219 +++++++++++++++++++++
 tb/tb_egress_frame_transmitter.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/egress_frame_transmitter.sv
// ---------------------------------------------------------------------------
// egress_frame_transmitter
//
// Transmit-side frame pump in the tx_clk domain. Pops one frame-length entry
// from the metadata FIFO, then streams that frame's 32-bit words from the data
// FIFO onto the MAC-facing EthernetTxBus. Frames seen while the link is down,
// or whose length is zero or above MAX_LEN, are drained from the data FIFO and
// counted as drops. They never reach the bus.
//
// Ports
//   tx_clk              transmit clock, rising edge
//   rst                 synchronous active-high reset (FIFOs share it)
//   link_up             PHY link status, already in tx_clk domain
//   meta_empty/meta_rd  metadata FIFO status / pop (data one cycle later)
//   meta_len            frame length in bytes
//   data_empty/data_rd  data FIFO status / pop (data one cycle later)
//   data_rdata          frame word, first wire byte in [31:24]
//   tx_ready            MAC can take a new frame start (sampled in IDLE)
//   tx_bus_start        one-cycle frame start strobe
//   tx_bus_data_valid   tx_bus_data carries a frame word
//   tx_bus_bytes_valid  valid bytes in tx_bus_data (1..4), left-aligned
//   tx_bus_data         frame word, unused bytes zero
//   frames_sent         saturating count of transmitted frames
//   frames_dropped      saturating count of drained / discarded frames
//   underflow           sticky: data_rd issued while data_empty was high
// ---------------------------------------------------------------------------
module egress_frame_transmitter #(
    parameter int MAX_LEN   = 1518,
    parameter int LEN_WIDTH = 11
) (
    input  logic                 tx_clk,
    input  logic                 rst,
    input  logic                 link_up,
    input  logic                 meta_empty,
    output logic                 meta_rd,
    input  logic [LEN_WIDTH-1:0] meta_len,
    input  logic                 data_empty,
    output logic                 data_rd,
    input  logic [31:0]          data_rdata,
    input  logic                 tx_ready,
    output logic                 tx_bus_start,
    output logic                 tx_bus_data_valid,
    output logic [2:0]           tx_bus_bytes_valid,
    output logic [31:0]          tx_bus_data,
    output logic [31:0]          frames_sent,
    output logic [15:0]          frames_dropped,
    output logic                 underflow
);

    // One extra bit so (len + 3) >> 2 cannot overflow at the largest length.
    localparam int WORDS_W = LEN_WIDTH + 1;

    typedef enum logic [2:0] {
        IDLE,
        META,
        START,
        DATA,
        DRAIN,
        GAP
    } state_t;

    state_t               state;
    logic [WORDS_W-1:0]   pop_left;    // words still to pop from the data FIFO
    logic [WORDS_W-1:0]   out_left;    // words still to place on the bus
    logic [2:0]           last_bytes;  // bytes_valid for the final word
    logic                 link_lost;   // link fell during the current frame

    logic [WORDS_W-1:0]   words_c;
    logic [2:0]           last_bytes_c;
    logic                 len_legal;
    logic                 load_word;
    logic                 word_last;
    logic                 word_show;
    logic [2:0]           word_bytes;
    logic [31:0]          word_mask;
    logic [31:0]          word_data;
    logic [31:0]          sent_next;
    logic [15:0]          dropped_next;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        words_c      = ({1'b0, meta_len} + WORDS_W'(3)) >> 2;
        last_bytes_c = (meta_len[1:0] == 2'b00) ? 3'd4 : {1'b0, meta_len[1:0]};
        len_legal    = (meta_len <= LEN_WIDTH'(MAX_LEN));

        // A bus word is loaded on the START edge and on every DATA edge until
        // all words are out; the final DATA edge only closes the frame.
        load_word  = (state == START) || ((state == DATA) && (out_left != '0));
        word_last  = (out_left == WORDS_W'(1));
        word_bytes = word_last ? last_bytes : 3'd4;
        word_show  = link_up && !link_lost;

        word_mask = 32'hFFFF_FFFF;
        case (word_bytes)
            3'd1:    word_mask = 32'hFF00_0000;
            3'd2:    word_mask = 32'hFFFF_0000;
            3'd3:    word_mask = 32'hFFFF_FF00;
            default: word_mask = 32'hFFFF_FFFF;
        endcase
        word_data = data_rdata & word_mask;

        sent_next    = (frames_sent == '1) ? frames_sent : frames_sent + 32'd1;
        dropped_next = (frames_dropped == '1) ? frames_dropped : frames_dropped + 16'd1;
    end

    // The FIFO pops are decoded from the current state rather than registered:
    // with one cycle of read latency, the first data word must be requested in
    // the same cycle meta_len is seen for the frame to start two cycles after
    // meta_rd and its first word to follow the start strobe directly.
    assign meta_rd = !rst && (state == IDLE) && !meta_empty && (tx_ready || !link_up);

    assign data_rd = !rst &&
                     (((state == META) && (meta_len != '0) && len_legal && link_up) ||
                      (((state == START) || (state == DATA)) && (pop_left != '0)) ||
                      (state == DRAIN));

    // NOTE: state and outputs are updated with non-blocking assignments so all
    // of them move together on the clock edge, independent of statement order.
    always_ff @(posedge tx_clk) begin
        if (rst) begin
            state              <= IDLE;
            pop_left           <= '0;
            out_left           <= '0;
            last_bytes         <= '0;
            link_lost          <= 1'b0;
            tx_bus_start       <= 1'b0;
            tx_bus_data_valid  <= 1'b0;
            tx_bus_bytes_valid <= '0;
            tx_bus_data        <= '0;
            frames_sent        <= '0;
            frames_dropped     <= '0;
            underflow          <= 1'b0;
        end else begin
            if (data_rd && data_empty) begin
                underflow <= 1'b1;
            end

            if (data_rd && (state inside {START, DATA, DRAIN})) begin
                pop_left <= pop_left - WORDS_W'(1);
            end

            // Once the link drops, the rest of the frame is still consumed
            // from the FIFO but never marked valid on the bus.
            if (load_word) begin
                out_left           <= out_left - WORDS_W'(1);
                tx_bus_data_valid  <= word_show;
                tx_bus_bytes_valid <= word_show ? word_bytes : 3'd0;
                tx_bus_data        <= word_show ? word_data : 32'd0;
                if (!link_up) begin
                    link_lost <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (meta_rd) begin
                        state <= META;
                    end
                end

                META: begin
                    last_bytes <= last_bytes_c;
                    link_lost  <= 1'b0;
                    if (meta_len == '0) begin
                        frames_dropped <= dropped_next;
                        state          <= GAP;
                    end else if (!len_legal || !link_up) begin
                        pop_left <= words_c;
                        state    <= DRAIN;
                    end else begin
                        // The first word is already being popped this cycle.
                        pop_left     <= words_c - WORDS_W'(1);
                        out_left     <= words_c;
                        tx_bus_start <= 1'b1;
                        state        <= START;
                    end
                end

                START: begin
                    tx_bus_start <= 1'b0;
                    state        <= DATA;
                end

                DATA: begin
                    if (out_left == '0) begin
                        tx_bus_data_valid  <= 1'b0;
                        tx_bus_bytes_valid <= '0;
                        tx_bus_data        <= '0;
                        if (link_lost) begin
                            frames_dropped <= dropped_next;
                        end else begin
                            frames_sent <= sent_next;
                        end
                        state <= GAP;
                    end
                end

                DRAIN: begin
                    if (pop_left == WORDS_W'(1)) begin
                        frames_dropped <= dropped_next;
                        state          <= GAP;
                    end
                end

                // One idle cycle so tx_ready is re-sampled after the MAC has
                // seen the end of the previous frame.
                GAP: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_egress_frame_transmitter.sv
// ---------------------------------------------------------------------------
// tb_egress_frame_transmitter
//
// Self-checking bench for egress_frame_transmitter. Behavioural FIFOs with one
// cycle of read latency feed the DUT; every frame expected on the bus pushes
// its words into a scoreboard that a negedge monitor pops and compares.
// ---------------------------------------------------------------------------
module tb_egress_frame_transmitter;

    localparam int LEN_WIDTH = 11;

    logic                 tx_clk = 1'b0;
    logic                 rst;
    logic                 link_up;
    logic                 meta_empty;
    logic                 meta_rd;
    logic [LEN_WIDTH-1:0] meta_len;
    logic                 data_empty;
    logic                 data_rd;
    logic [31:0]          data_rdata;
    logic                 tx_ready;
    logic                 tx_bus_start;
    logic                 tx_bus_data_valid;
    logic [2:0]           tx_bus_bytes_valid;
    logic [31:0]          tx_bus_data;
    logic [31:0]          frames_sent;
    logic [15:0]          frames_dropped;
    logic                 underflow;

    egress_frame_transmitter #(
        .MAX_LEN   (1518),
        .LEN_WIDTH (LEN_WIDTH)
    ) dut (
        .tx_clk             (tx_clk),
        .rst                (rst),
        .link_up            (link_up),
        .meta_empty         (meta_empty),
        .meta_rd            (meta_rd),
        .meta_len           (meta_len),
        .data_empty         (data_empty),
        .data_rd            (data_rd),
        .data_rdata         (data_rdata),
        .tx_ready           (tx_ready),
        .tx_bus_start       (tx_bus_start),
        .tx_bus_data_valid  (tx_bus_data_valid),
        .tx_bus_bytes_valid (tx_bus_bytes_valid),
        .tx_bus_data        (tx_bus_data),
        .frames_sent        (frames_sent),
        .frames_dropped     (frames_dropped),
        .underflow          (underflow)
    );

    always #5 tx_clk = ~tx_clk;

    typedef struct packed {
        logic [31:0] data;
        logic [2:0]  bytes;
    } exp_t;

    exp_t                 sb[$];
    logic [LEN_WIDTH-1:0] meta_q[$];
    logic [31:0]          data_q[$];

    int n_checks = 0;
    int n_errors = 0;

    int   cyc = 0;
    logic link_prev = 1'b1;
    int   meta_pops = 0;
    int   data_pops = 0;
    int   starts = 0;
    int   last_meta_cyc = 0;
    int   start_cyc = 0;
    int   last_valid_cyc = 0;
    bit   first_word = 1'b0;
    int   start_cycs[$];

    int b_meta, b_data, b_starts;
    int b_sent, b_dropped;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Cycle counter and link status as seen by the DUT at each edge.
    initial begin
        forever begin
            @(posedge tx_clk);
            cyc++;
            link_prev = link_up;
        end
    end

    // Behavioural FIFOs: pops requested in a cycle are served just after the
    // following edge.
    initial begin
        bit mrd, drd, rs;
        meta_empty = 1'b1;
        data_empty = 1'b1;
        meta_len   = '0;
        data_rdata = '0;
        forever begin
            @(negedge tx_clk);
            mrd = meta_rd;
            drd = data_rd;
            rs  = rst;
            @(posedge tx_clk);
            #1;
            if (rs) begin
                meta_q.delete();
                data_q.delete();
            end else begin
                if (mrd && meta_q.size() > 0) meta_len = meta_q.pop_front();
                if (drd) begin
                    if (data_q.size() > 0) data_rdata = data_q.pop_front();
                    else data_rdata = 32'h0;
                end
            end
            meta_empty = (meta_q.size() == 0);
            data_empty = (data_q.size() == 0);
        end
    end

    // Bus monitor and scoreboard consumer.
    initial begin
        exp_t e;
        forever begin
            @(negedge tx_clk);
            if (meta_rd) begin
                meta_pops++;
                last_meta_cyc = cyc;
            end
            if (data_rd) data_pops++;
            if (tx_bus_start) begin
                starts++;
                check("start_after_meta_rd", cyc - last_meta_cyc, 2);
                start_cyc  = cyc;
                start_cycs.push_back(cyc);
                first_word = 1'b1;
            end
            if (!link_prev) begin
                check("valid_while_link_down", tx_bus_data_valid, 0);
            end else if (tx_bus_data_valid) begin
                if (first_word) check("first_word_after_start", cyc - start_cyc, 1);
                else check("word_gap", cyc - last_valid_cyc, 1);
                first_word     = 1'b0;
                last_valid_cyc = cyc;
                if (sb.size() == 0) begin
                    check("unexpected_valid", tx_bus_data_valid, 0);
                end else begin
                    e = sb.pop_front();
                    check("tx_data", tx_bus_data, e.data);
                    check("tx_bytes", tx_bus_bytes_valid, e.bytes);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge tx_clk);
        #2;
    endtask

    function automatic logic [2:0] bytes_for(input int len, input int idx);
        int w;
        w = (len + 3) / 4;
        if (idx != w - 1) return 3'd4;
        if (len % 4 == 0) return 3'd4;
        return 3'(len % 4);
    endfunction

    task automatic push_word(input logic [31:0] w, input int len, input int idx, input bit tx);
        exp_t e;
        logic [31:0] m;
        data_q.push_back(w);
        if (tx) begin
            e.bytes = bytes_for(len, idx);
            case (e.bytes)
                3'd1:    m = 32'hFF00_0000;
                3'd2:    m = 32'hFFFF_0000;
                3'd3:    m = 32'hFFFF_FF00;
                default: m = 32'hFFFF_FFFF;
            endcase
            e.data = w & m;
            sb.push_back(e);
        end
    endtask

    task automatic push_frame(input int len, input bit tx);
        for (int i = 0; i < (len + 3) / 4; i++) push_word($urandom, len, i, tx);
        meta_q.push_back(LEN_WIDTH'(len));
    endtask

    task automatic snap();
        b_meta    = meta_pops;
        b_data    = data_pops;
        b_starts  = starts;
        b_sent    = int'(frames_sent);
        b_dropped = int'(frames_dropped);
    endtask

    task automatic wait_quiet(input int budget);
        int q = 0;
        int n = 0;
        while (q < 4 && n < budget) begin
            tick(1);
            n++;
            if (meta_q.size() == 0 && !meta_rd && !data_rd && !tx_bus_start && !tx_bus_data_valid) q++;
            else q = 0;
        end
        if (n >= budget) check("wait_quiet_timeout", q, 4);
    endtask

    task automatic wait_start(input int budget);
        int n = 0;
        while (starts == b_starts && n < budget) begin
            tick(1);
            n++;
        end
        check("start_seen", starts - b_starts, 1);
    endtask

    initial begin
        logic [31:0] t1 [5];
        int n;

        rst      = 1'b1;
        link_up  = 1'b1;
        tx_ready = 1'b1;
        tick(3);
        check("rst_strobes", {meta_rd, data_rd, tx_bus_start}, 0);
        check("rst_bus", {tx_bus_data_valid, tx_bus_bytes_valid, tx_bus_data}, 0);
        check("rst_counters", {frames_sent, frames_dropped, underflow}, 0);
        rst = 1'b0;
        tick(2);

        // 19-byte frame; last word partially valid with its tail zeroed.
        snap();
        t1[0] = 32'hfeedface; t1[1] = 32'hdeadbeef; t1[2] = 32'hcafef00d;
        t1[3] = 32'hbaadc0de; t1[4] = 32'h414141ff;
        for (int i = 0; i < 5; i++) push_word(t1[i], 19, i, 1'b1);
        meta_q.push_back(LEN_WIDTH'(19));
        wait_quiet(200);
        check("f19_sent", frames_sent, 1);
        check("f19_starts", starts - b_starts, 1);
        check("f19_pops", data_pops - b_data, 5);
        check("f19_sb_empty", sb.size(), 0);

        // 64-byte then 60-byte frame back to back.
        snap();
        push_frame(64, 1'b1);
        push_frame(60, 1'b1);
        wait_quiet(300);
        n = start_cycs.size();
        check("b2b_starts", starts - b_starts, 2);
        check("b2b_spacing", start_cycs[n-1] - start_cycs[n-2], 20);
        check("b2b_sent", frames_sent, b_sent + 2);
        check("b2b_sb_empty", sb.size(), 0);

        // tx_ready low holds a queued frame.
        tx_ready = 1'b0;
        snap();
        push_frame(12, 1'b1);
        tick(20);
        check("hold_no_meta_rd", meta_pops - b_meta, 0);
        check("hold_no_start", starts - b_starts, 0);
        tx_ready = 1'b1;
        wait_quiet(200);
        check("release_start", starts - b_starts, 1);
        check("release_sent", frames_sent, b_sent + 1);

        // Link down: both frames drained regardless of tx_ready.
        link_up  = 1'b0;
        tx_ready = 1'b0;
        snap();
        push_frame(10, 1'b0);
        push_frame(1600, 1'b0);
        wait_quiet(2000);
        check("linkdown_pops", data_pops - b_data, 403);
        check("linkdown_no_start", starts - b_starts, 0);
        check("linkdown_dropped", frames_dropped, b_dropped + 2);
        link_up  = 1'b1;
        tx_ready = 1'b1;
        tick(2);

        // Oversize frame with link up is drained too.
        snap();
        push_frame(1600, 1'b0);
        wait_quiet(2000);
        check("oversize_pops", data_pops - b_data, 400);
        check("oversize_no_start", starts - b_starts, 0);
        check("oversize_dropped", frames_dropped, b_dropped + 1);

        // Zero-length entry, then a normal 8-byte frame.
        snap();
        meta_q.push_back('0);
        wait_quiet(200);
        check("len0_pops", data_pops - b_data, 0);
        check("len0_no_start", starts - b_starts, 0);
        check("len0_dropped", frames_dropped, b_dropped + 1);
        snap();
        push_frame(8, 1'b1);
        wait_quiet(200);
        check("after_len0_sent", frames_sent, b_sent + 1);
        check("after_len0_sb_empty", sb.size(), 0);

        // Link falls mid-way through a 40-byte frame.
        snap();
        push_frame(40, 1'b1);
        wait_start(100);
        tick(3);
        link_up = 1'b0;
        wait_quiet(200);
        link_up = 1'b1;
        check("midloss_suppressed", sb.size() != 0, 1);
        sb.delete();
        check("midloss_pops", data_pops - b_data, 10);
        check("midloss_fifo_empty", data_q.size(), 0);
        check("midloss_dropped", frames_dropped, b_dropped + 1);
        check("midloss_sent", frames_sent, b_sent);
        tick(2);

        // Underflow: a frame whose data never arrived, drained with link down.
        check("underflow_clear", underflow, 0);
        link_up = 1'b0;
        snap();
        meta_q.push_back(LEN_WIDTH'(4));
        wait_quiet(200);
        check("underflow_set", underflow, 1);
        check("underflow_dropped", frames_dropped, b_dropped + 1);
        link_up = 1'b1;
        tick(2);

        // Reset mid-frame clears everything on the next cycle.
        snap();
        push_frame(40, 1'b1);
        wait_start(100);
        tick(2);
        rst = 1'b1;
        tick(1);
        check("midrst_strobes", {meta_rd, data_rd, tx_bus_start}, 0);
        check("midrst_bus", {tx_bus_data_valid, tx_bus_bytes_valid, tx_bus_data}, 0);
        check("midrst_counters", {frames_sent, frames_dropped, underflow}, 0);
        rst = 1'b0;
        sb.delete();
        tick(2);
        snap();
        push_frame(8, 1'b1);
        wait_quiet(200);
        check("post_rst_sent", frames_sent, 1);
        check("post_rst_sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
